// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if: decode inputs, stall/flush controls and per-stage control outputs
interface ctrl_pipeline_if #(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 8
);
   logic [5:0]         op_d;
   logic               valid_d, stall_e, flush_e;
   logic               jump_d, branch_d, bne_d, illegal_d;
   logic               regwrite_e, regdst_e, alusrc_e, memwrite_e, memtoreg_e, link_e, valid_e;
   logic [ALUOP_W-1:0] aluop_e;
   logic               regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m;
   logic               regwrite_w, memtoreg_w, link_w, valid_w;
   logic [CNT_W-1:0]   ill_cnt;
   modport master (
      output op_d, valid_d, stall_e, flush_e,
      input  jump_d, branch_d, bne_d, illegal_d,
      input  regwrite_e, regdst_e, alusrc_e, memwrite_e, memtoreg_e, link_e, valid_e, aluop_e,
      input  regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m,
      input  regwrite_w, memtoreg_w, link_w, valid_w, ill_cnt
   );
   modport slave (
      input  op_d, valid_d, stall_e, flush_e,
      output jump_d, branch_d, bne_d, illegal_d,
      output regwrite_e, regdst_e, alusrc_e, memwrite_e, memtoreg_e, link_e, valid_e, aluop_e,
      output regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m,
      output regwrite_w, memtoreg_w, link_w, valid_w, ill_cnt
   );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: opcode decode plus E/M/W control pipeline with stall, flush and illegal-opcode counting
module ctrl_pipeline #(
   parameter int ALUOP_W = 3,
   parameter int EXT_EN  = 1,
   parameter int CNT_W   = 8
) (
   input logic            clk,
   input logic            rst,
   ctrl_pipeline_if.slave bus
);
   typedef struct packed {
      logic regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, link;
      logic [2:0] aluop;
   } dec_t;
   typedef struct packed {
      logic regwrite, regdst, alusrc, memwrite, memtoreg, link, valid;
      logic [ALUOP_W-1:0] aluop;
   } e_t;
   typedef struct packed {
      logic regwrite, memwrite, memtoreg, link, valid;
   } m_t;
   typedef struct packed {
      logic regwrite, memtoreg, link, valid;
   } w_t;
   dec_t             dec;
   logic             legal, ext, cap;
   e_t               e_new, e_d, e_q;
   m_t               m_d, m_q;
   w_t               w_d, w_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // opcode table; extended opcodes decode as illegal when EXT_EN is 0
   always_comb begin
      dec   = '0;
      legal = 1'b1;
      ext   = 1'b0;
      case (bus.op_d)
         6'b000000: dec = 12'b110000000_010;
         6'b100011: dec = 12'b101000100_000;
         6'b101011: dec = 12'b001001000_000;
         6'b000100: dec = 12'b000100000_001;
         6'b001000: dec = 12'b101000000_000;
         6'b000010: dec = 12'b000000010_000;
         6'b000101: begin dec = 12'b000110000_001; ext = 1'b1; end
         6'b001100: begin dec = 12'b101000000_011; ext = 1'b1; end
         6'b001101: begin dec = 12'b101000000_100; ext = 1'b1; end
         6'b001010: begin dec = 12'b101000000_101; ext = 1'b1; end
         6'b001111: begin dec = 12'b101000000_110; ext = 1'b1; end
         6'b000011: begin dec = 12'b100000011_000; ext = 1'b1; end
         default:   legal = 1'b0;
      endcase
      if (ext && EXT_EN == 0) begin
         dec   = '0;
         legal = 1'b0;
      end
   end

   assign bus.illegal_d = bus.valid_d & ~legal;
   assign bus.jump_d    = bus.valid_d & dec.jump;
   assign bus.branch_d  = bus.valid_d & dec.branch;
   assign bus.bne_d     = bus.valid_d & dec.bne;
   assign cap           = bus.valid_d & legal;

   // next state: flush beats stall for E; a stall without flush bubbles M; W always follows M
   always_comb begin
      e_new = {dec.regwrite, dec.regdst, dec.alusrc, dec.memwrite, dec.memtoreg, dec.link, 1'b1, ALUOP_W'(dec.aluop)};
      e_d   = bus.flush_e ? '0 : (bus.stall_e ? e_q : (cap ? e_new : '0));
      m_d   = '0;
      if (!(bus.stall_e && !bus.flush_e))
         m_d = {e_q.regwrite, e_q.memwrite, e_q.memtoreg, e_q.link, e_q.valid};
      w_d   = {m_q.regwrite, m_q.memtoreg, m_q.link, m_q.valid};
      cnt_d = (bus.illegal_d && !bus.stall_e && !bus.flush_e && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // stage registers and illegal counter; reset overrides stall and flush
   always_ff @(posedge clk) begin
      if (rst) begin
         e_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.regwrite_e = e_q.regwrite & e_q.valid;
   assign bus.regdst_e   = e_q.regdst & e_q.valid;
   assign bus.alusrc_e   = e_q.alusrc & e_q.valid;
   assign bus.memwrite_e = e_q.memwrite & e_q.valid;
   assign bus.memtoreg_e = e_q.memtoreg & e_q.valid;
   assign bus.link_e     = e_q.link & e_q.valid;
   assign bus.valid_e    = e_q.valid;
   assign bus.aluop_e    = e_q.aluop & {ALUOP_W{e_q.valid}};
   assign bus.regwrite_m = m_q.regwrite & m_q.valid;
   assign bus.memwrite_m = m_q.memwrite & m_q.valid;
   assign bus.memtoreg_m = m_q.memtoreg & m_q.valid;
   assign bus.link_m     = m_q.link & m_q.valid;
   assign bus.valid_m    = m_q.valid;
   assign bus.regwrite_w = w_q.regwrite & w_q.valid;
   assign bus.memtoreg_w = w_q.memtoreg & w_q.valid;
   assign bus.link_w     = w_q.link & w_q.valid;
   assign bus.valid_w    = w_q.valid;
   assign bus.ill_cnt    = cnt_q;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: random and directed stimulus on EXT_EN=1 and EXT_EN=0 instances against a table-driven model
module tb_ctrl_pipeline;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_pipeline_if #(.ALUOP_W(3), .CNT_W(8)) b1 ();
   ctrl_pipeline_if #(.ALUOP_W(3), .CNT_W(8)) b0 ();
   ctrl_pipeline #(.ALUOP_W(3), .EXT_EN(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   ctrl_pipeline #(.ALUOP_W(3), .EXT_EN(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));

   int n_chk = 0;
   int n_err = 0;
   logic [3:0] c_vec [2];
   logic [9:0] e_vec [2];
   logic [4:0] m_vec [2];
   logic [3:0] w_vec [2];
   logic [7:0] cnt_vec [2];
   assign c_vec[1]   = {b1.illegal_d, b1.jump_d, b1.branch_d, b1.bne_d};
   assign c_vec[0]   = {b0.illegal_d, b0.jump_d, b0.branch_d, b0.bne_d};
   assign e_vec[1]   = {b1.regwrite_e, b1.regdst_e, b1.alusrc_e, b1.memwrite_e, b1.memtoreg_e, b1.link_e, b1.valid_e, b1.aluop_e};
   assign e_vec[0]   = {b0.regwrite_e, b0.regdst_e, b0.alusrc_e, b0.memwrite_e, b0.memtoreg_e, b0.link_e, b0.valid_e, b0.aluop_e};
   assign m_vec[1]   = {b1.regwrite_m, b1.memwrite_m, b1.memtoreg_m, b1.link_m, b1.valid_m};
   assign m_vec[0]   = {b0.regwrite_m, b0.memwrite_m, b0.memtoreg_m, b0.link_m, b0.valid_m};
   assign w_vec[1]   = {b1.regwrite_w, b1.memtoreg_w, b1.link_w, b1.valid_w};
   assign w_vec[0]   = {b0.regwrite_w, b0.memtoreg_w, b0.link_w, b0.valid_w};
   assign cnt_vec[1] = b1.ill_cnt;
   assign cnt_vec[0] = b0.ill_cnt;

   // table row: regwrite regdst alusrc branch bne memwrite memtoreg jump link aluop[2:0]
   bit [11:0] tbl [bit [5:0]];
   bit        is_ext [bit [5:0]];
   bit [5:0]  ops [12];
   // model records {valid, table row} per stage, per instance (index = EXT_EN)
   logic [12:0] me [2], mm [2], mw [2];
   int          mcnt [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input bit [5:0] op, input int ext);
      return tbl.exists(op) && (ext != 0 || !is_ext.exists(op));
   endfunction

   function automatic bit [11:0] row(input bit [5:0] op, input int ext);
      return is_legal(op, ext) ? tbl[op] : 12'h0;
   endfunction

   task automatic cycle(input bit [5:0] op, input bit v, input bit st, input bit fl, input bit r);
      bit [11:0] d;
      bit [12:0] rec;
      rst = r;
      b1.op_d = op; b1.valid_d = v; b1.stall_e = st; b1.flush_e = fl;
      b0.op_d = op; b0.valid_d = v; b0.stall_e = st; b0.flush_e = fl;
      #1;
      for (int k = 0; k < 2; k++) begin
         d = row(op, k);
         check($sformatf("dec%0d op=%b", k, op), 32'(c_vec[k]),
               32'({v && !is_legal(op, k), v && d[4], v && d[8], v && d[7]}));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            me[k] = '0; mm[k] = '0; mw[k] = '0; mcnt[k] = 0;
         end else begin
            mw[k] = mm[k];
            mm[k] = (st && !fl) ? 13'h0 : me[k];
            if (fl) me[k] = '0;
            else if (!st) me[k] = (v && is_legal(op, k)) ? {1'b1, row(op, k)} : 13'h0;
            if (v && !is_legal(op, k) && !st && !fl && mcnt[k] < 255) mcnt[k]++;
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         rec = me[k];
         check($sformatf("e%0d", k), 32'(e_vec[k]),
               rec[12] ? 32'({rec[11], rec[10], rec[9], rec[6], rec[5], rec[3], 1'b1, rec[2:0]}) : 32'h0);
         rec = mm[k];
         check($sformatf("m%0d", k), 32'(m_vec[k]), rec[12] ? 32'({rec[11], rec[6], rec[5], rec[3], 1'b1}) : 32'h0);
         rec = mw[k];
         check($sformatf("w%0d", k), 32'(w_vec[k]), rec[12] ? 32'({rec[11], rec[5], rec[3], 1'b1}) : 32'h0);
         check($sformatf("cnt%0d", k), 32'(cnt_vec[k]), 32'(mcnt[k]));
      end
   endtask

   initial begin
      tbl[6'b000000] = 12'b110000000_010;
      tbl[6'b100011] = 12'b101000100_000;
      tbl[6'b101011] = 12'b001001000_000;
      tbl[6'b000100] = 12'b000100000_001;
      tbl[6'b001000] = 12'b101000000_000;
      tbl[6'b000010] = 12'b000000010_000;
      tbl[6'b000101] = 12'b000110000_001;
      tbl[6'b001100] = 12'b101000000_011;
      tbl[6'b001101] = 12'b101000000_100;
      tbl[6'b001010] = 12'b101000000_101;
      tbl[6'b001111] = 12'b101000000_110;
      tbl[6'b000011] = 12'b100000011_000;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010,
              6'b000101, 6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b000011};
      for (int i = 6; i < 12; i++) is_ext[ops[i]] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         me[k] = '0; mm[k] = '0; mw[k] = '0; mcnt[k] = 0;
      end
      cycle(6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_state", 32'({e_vec[1], m_vec[1], w_vec[1], cnt_vec[1]}), 32'h0);
      // lw latency
      cycle(6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lw_e", 32'(e_vec[1]), 32'(10'b101010_1_000));
      cycle(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lw_w", 32'(w_vec[1]), 32'(4'b1101));
      // beq held by a two-cycle stall, then R-type enters
      cycle(6'b000100, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cycle(6'b000000, 1'b1, 1'b1, 1'b0, 1'b0);
         check("stall_e_beq", 32'(e_vec[1]), 32'(10'b000000_1_001));
         check("stall_m_bubble", 32'(m_vec[1]), 32'h0);
      end
      cycle(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
      check("release_r", 32'(e_vec[1]), 32'(10'b110000_1_010));
      // flush wins over stall
      cycle(6'b101011, 1'b1, 1'b1, 1'b1, 1'b0);
      check("flush_stall_e", 32'(e_vec[1]), 32'h0);
      // jal on both instances
      b1.op_d = 6'b000011; b1.valid_d = 1'b1; b1.stall_e = 1'b0; b1.flush_e = 1'b0;
      b0.op_d = 6'b000011; b0.valid_d = 1'b1; b0.stall_e = 1'b0; b0.flush_e = 1'b0;
      #1;
      check("jal_jump1", 32'(b1.jump_d), 32'h1);
      check("jal_ill0", 32'(b0.illegal_d), 32'h1);
      check("jal_jump0", 32'(b0.jump_d), 32'h0);
      cycle(6'b000011, 1'b1, 1'b0, 1'b0, 1'b0);
      check("jal_e1", 32'({b1.link_e, b1.regwrite_e}), 32'h3);
      check("jal_e0", 32'({b0.link_e, b0.valid_e}), 32'h0);
      // saturation of the illegal counter
      for (int i = 0; i < 300; i++) cycle(6'b111111, 1'b1, 1'b0, 1'b0, 1'b0);
      check("sat1", 32'(cnt_vec[1]), 32'd255);
      check("sat0", 32'(cnt_vec[0]), 32'd255);
      check("sat_valid_e", 32'(b1.valid_e), 32'h0);
      // reset mid-stream overrides stall and flush
      for (int i = 0; i < 3; i++) cycle(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(6'b000000, 1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_mid", 32'({b1.valid_e, b1.valid_m, b1.valid_w, b1.ill_cnt}), 32'h0);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         bit [5:0] op;
         op = ($urandom_range(3) == 0) ? 6'($urandom) : ops[$urandom_range(11)];
         cycle(op, $urandom_range(9) < 8, $urandom_range(4) == 0,
               $urandom_range(9) == 0, $urandom_range(39) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 3, the width of the ALU operation code.
REQ-002 The block SHALL have parameter EXT_EN, default 1; when 0, only R, lw, sw, beq, addi and j are legal opcodes.
REQ-003 The block SHALL have parameter CNT_W, default 8, the width of the illegal-opcode counter.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: port clk, input, 1 bit, rising-edge clock.
REQ-005 Port rst, input, 1 bit, synchronous active-high reset.
REQ-006 Port op_d, input, 6 bits, opcode of the instruction in decode.
REQ-007 Port valid_d, input, 1 bit, decode slot holds a real instruction.
REQ-008 Port stall_e, input, 1 bit, hold the E register.
REQ-009 Port flush_e, input, 1 bit, load a bubble into the E register.
REQ-010 Port jump_d, output, 1 bit; port branch_d, output, 1 bit; port bne_d, output, 1 bit: combinational decode-stage control.
REQ-011 Ports regwrite_e, regdst_e, alusrc_e, memwrite_e, memtoreg_e, link_e, valid_e: outputs, 1 bit each; port aluop_e, output, ALUOP_W bits.
REQ-012 Ports regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m: outputs, 1 bit each.
REQ-013 Ports regwrite_w, memtoreg_w, link_w, valid_w: outputs, 1 bit each.
REQ-014 Port illegal_d, output, 1 bit: combinational flag, valid_d with an undecodable opcode.
REQ-015 Port ill_cnt, output, CNT_W bits: saturating count of illegal opcodes.

Function
REQ-016 Decode SHALL be combinational from op_d using this table, giving regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, link, aluop:
  000000 R: 1,1,0,0,0,0,0,0,0,010
  100011 lw: 1,0,1,0,0,0,1,0,0,000
  101011 sw: 0,0,1,0,0,1,0,0,0,000
  000100 beq: 0,0,0,1,0,0,0,0,0,001
  001000 addi: 1,0,1,0,0,0,0,0,0,000
  000010 j: 0,0,0,0,0,0,0,1,0,000
  EXT_EN=1 only:
  000101 bne: 0,0,0,1,1,0,0,0,0,001
  001100 andi: 1,0,1,0,0,0,0,0,0,011
  001101 ori: 1,0,1,0,0,0,0,0,0,100
  001010 slti: 1,0,1,0,0,0,0,0,0,101
  001111 lui: 1,0,1,0,0,0,0,0,0,110
  000011 jal: 1,0,0,0,0,0,0,1,1,000
REQ-017 Any other opcode SHALL decode to all-zero control, never X or Z; illegal_d SHALL equal valid_d AND the opcode is not in the table.
REQ-018 jump_d, branch_d and bne_d SHALL be gated by valid_d.
REQ-019 E-stage update priority: rst, then flush_e (E := bubble), then stall_e (E holds), else E := decoded control, with valid_e := valid_d AND NOT illegal_d.
REQ-020 A bubble SHALL have all control bits, aluop and valid at 0.
REQ-021 When stall_e=1 and flush_e=0, M SHALL load a bubble; otherwise M := E. W := M every cycle.
REQ-022 All stage control outputs SHALL be the stored bits ANDed with the stage valid.
REQ-023 An illegal opcode SHALL enter E as a bubble.
REQ-024 ill_cnt SHALL increment by 1 when illegal_d=1, stall_e=0 and flush_e=0, and SHALL saturate at 2^CNT_W-1.
REQ-025 Latency: decoded control SHALL appear in E 1 cycle, M 2 cycles and W 3 cycles after capture, absent stall or flush.

Reset
REQ-026 While rst=1 at a rising edge, all E, M and W registers and ill_cnt SHALL become 0. Decode-stage outputs stay combinational.
REQ-027 A reset during a stall or flush SHALL override both.

Verification
REQ-028 lw (100011) with valid_d=1, one cycle -> cycle+1: regwrite_e=1, alusrc_e=1, memtoreg_e=1, aluop_e=000; cycle+3: regwrite_w=1, memtoreg_w=1.
REQ-029 beq followed by R-type with stall_e=1 for 2 cycles -> E holds the beq (valid_e=1, aluop_e=001); M shows bubbles for 2 cycles; the R-type enters E on release.
REQ-030 stall_e=1 and flush_e=1 together with sw in decode -> E becomes a bubble: valid_e=0, memwrite_e=0.
REQ-031 Opcode 111111, valid_d=1, 300 cycles, CNT_W=8 -> illegal_d=1 each cycle, valid_e=0, ill_cnt saturates at 255.
REQ-032 EXT_EN=0 with jal (000011) -> illegal_d=1, link_e=0; EXT_EN=1 -> link_e=1, regwrite_e=1, jump_d=1.
REQ-033 rst asserted for 1 cycle mid-stream with valid stages -> next cycle valid_e, valid_m, valid_w and ill_cnt are all 0.
